// File: rtl/sysarray_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: array geometry,
// operand/PE latencies, derived counter widths, drain length and the
// controller state encoding.
package sysarray_ctrl_pkg;

  localparam int N      = 4;    // array dimension (rows = columns)
  localparam int K_MAX  = 256;  // longest reduction per tile
  localparam int RD_LAT = 1;    // operand buffer read latency
  localparam int PE_LAT = 1;    // sysblock register latency per hop

  localparam int KW = $clog2(K_MAX + 1);  // holds k_len up to K_MAX
  localparam int AW = $clog2(K_MAX);      // operand buffer address
  localparam int RW = $clog2(N);          // result row index

  // Cycles from the last operand read until the far corner PE has its
  // final product folded in: buffer latency, skew across rows plus
  // columns, and the last accumulate.
  localparam int D = RD_LAT + 2 * (N - 1) + PE_LAT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/sysarray_ctrl_skew_line.sv
// Skewed feed-enable generator: a shift register of the operand read
// strobe. Tap i is the read strobe delayed by RD_LAT+i cycles, so row i /
// column i sees valid operands exactly when its buffer data arrives.
module sysarray_ctrl_skew_line
  import sysarray_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rd_en,
  output logic [N-1:0] feed_en
);

  localparam int DEPTH = N + RD_LAT - 1;

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH:0]   line;

  // line[j] is rd_en delayed by j cycles
  assign line    = {sr_q, rd_en};
  assign feed_en = line[RD_LAT +: N];

  // Shift the read strobe one stage per cycle, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= line[DEPTH-1:0];
  end

endmodule

// File: rtl/sysarray_ctrl.sv
// Output-stationary tile sequencer for an N x N sysblock MAC array:
// clear accumulators, stream K operand reads, wait out the array drain,
// then hand result rows downstream.
// Optional build macro SYSCTRL_PERF_EN adds busy/stall cycle counters.
//
// Result port handshake: out_valid is high for the whole OUT phase and
// out_row is stable while out_valid && !out_ready; a row transfers on any
// cycle with out_valid && out_ready, after which out_row advances (or the
// tile completes after row N-1 and done pulses in the following cycle).
module sysarray_ctrl
  import sysarray_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [N-1:0]  feed_en,
  output logic          pe_clr,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  input  logic          out_ready,
  output logic [2:0]    dbg_state
`ifdef SYSCTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stall
`endif
);

  state_e        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;    // k index in FEED, drain count in DRAIN
  logic [KW-1:0] klen_q, klen_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      row_q   <= row_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter updates and completion/refusal pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    row_d   = row_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (k_len == '0 || k_len > KW'(K_MAX)) begin
            err_d = 1'b1;
          end else begin
            klen_d  = k_len;
            cnt_d   = '0;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (cnt_q == klen_q - 1'b1) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == KW'(D - 1)) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; PEs stay cleared for as long as reset is held
  always_comb begin
    busy      = (state_q != ST_IDLE);
    rd_en     = (state_q == ST_FEED);
    rd_addr   = rd_en ? cnt_q[AW-1:0] : '0;
    out_valid = (state_q == ST_OUT);
    out_row   = row_q;
    pe_clr    = !rst || (state_q == ST_CLEAR);
    done      = done_q;
    err       = err_q;
    dbg_state = state_q;
  end

  sysarray_ctrl_skew_line u_skew (
    .clk     (clk),
    .rst_n   (rst),
    .rd_en   (rd_en),
    .feed_en (feed_en)
  );

`ifdef SYSCTRL_PERF_EN
  // Saturating busy-cycle and output-stall counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != 32'hFFFF_FFFF)
        perf_cycles <= perf_cycles + 32'd1;
      if (out_valid && !out_ready && perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sysarray_ctrl.md
Name: sysarray_ctrl

Overview:
Sequencer for an N x N grid of sysblock float32 MAC PEs running one output-stationary matrix tile.
- Clears the PE accumulators.
- Issues K operand reads to the A-row and B-column buffers.
- Generates skewed per-row/per-column feed enables and waits out the array drain.
- Hands results out row by row over a valid/ready port.
- Sits between the tile scheduler (start/done) and the array plus its operand buffers.

Parameters:
N, 4, array dimension (rows = columns)
K_MAX, 256, maximum reduction length per tile
RD_LAT, 1, operand buffer read latency in cycles
PE_LAT, 1, sysblock register latency per hop (up->down, left->right, res update)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin tile; sampled only in IDLE
k_len  in  clog2(K_MAX+1)  reduction length; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last result row accepted
err  out  1  one-cycle pulse when start is refused (k_len==0 or k_len>K_MAX)
rd_en  out  1  read strobe to A and B operand buffers
rd_addr  out  clog2(K_MAX)  reduction index k
feed_en  out  N  bit i = operand valid at array row i / column i input (skewed)
pe_clr  out  1  active-high clear to all sysblock rst inputs
out_valid  out  1  result row available
out_row  out  clog2(N)  index of result row presented
out_ready  in  1  downstream accepts row

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE.
  - pe_clr=1, held while rst is low so the PEs are cleared together with the controller.
  - All other outputs 0, including feed_en.
  - The skew pipeline is flushed.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> OUT -> IDLE.
- IDLE:
  - pe_clr=0.
  - start with 1<=k_len<=K_MAX: latch k_len, go to CLEAR.
  - start with an illegal k_len: err=1 for one cycle, stay in IDLE.
- CLEAR: exactly 1 cycle, pe_clr=1. Go to FEED.
- FEED:
  - k_len cycles, rd_en=1.
  - rd_addr = 0,1,...,k_len-1, one increment per cycle.
  - After the cycle with rd_addr=k_len-1, go to DRAIN.
- DRAIN:
  - rd_en=0.
  - Counter runs for D = RD_LAT + 2*(N-1) + PE_LAT cycles (N=4, RD_LAT=1, PE_LAT=1 gives D=8), then go to OUT.
- feed_en[i] = rd_en delayed by RD_LAT+i cycles. It is driven from a shift register independent of state, so it keeps emptying during DRAIN.
- OUT:
  - out_valid=1, out_row starts at 0.
  - A transfer occurs when out_valid && out_ready; out_row then increments.
  - The transfer with out_row=N-1 returns the state to IDLE and pulses done in that same next cycle.
  - out_row is held stable while out_ready=0.
- start while busy: ignored, no err.
- rst asserted mid-operation: immediate return to IDLE per reset values. Any partially fed tile is lost; there is no done.
- Counter widths: the k counter compares against the latched k_len, never the live input. No wrap-around is possible because k_len is bounds-checked.

Optional Feature:
SYSCTRL_PERF_EN
- Defined:
  - Adds output perf_cycles[31:0], counting cycles with busy=1, saturating at 0xFFFFFFFF.
  - Adds perf_stall[31:0], counting OUT cycles with out_ready=0.
  - Both are cleared by rst only.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header sysarray_defs holds:
  - the state encoding (IDLE, CLEAR, FEED, DRAIN, OUT)
  - default N, K_MAX, RD_LAT, PE_LAT
  - derived widths KW = clog2(K_MAX+1), AW = clog2(K_MAX), RW = clog2(N)
  - drain length D
- One sub-module, skew_line:
  - N+RD_LAT-1 deep enable shift register with asynchronous active-low clear.
  - Taps produce feed_en.

Test Plan:
1. N=4, k_len=3, start at cycle 0, out_ready=1 -> pe_clr cycle 1; rd_en cycles 2-4 with rd_addr 0,1,2; feed_en[0] cycles 3-5; feed_en[3] cycles 6-8; out_valid cycles 13-16 with out_row 0..3; done cycle 17; busy cycles 1-16.
2. k_len=0 and k_len=257 at start -> err one cycle each; busy stays 0; rd_en never asserted.
3. OUT backpressure: out_ready low for 3 cycles at out_row=1 -> out_row holds 1, out_valid stays 1; done delayed 3 cycles vs scenario 1.
4. start pulsed again during FEED and during OUT -> no effect; rd_addr sequence and done timing identical to scenario 1.
5. rst driven low at FEED cycle with rd_addr=1 -> same cycle: busy=0, rd_en=0, feed_en=0, pe_clr=1; after release, start with k_len=1 -> normal tile, done at cycle 15 relative to start.
6. k_len=256 -> rd_addr reaches 255 then rd_en drops; no address wrap; DRAIN of exactly 8 cycles; 4 rows out; done asserted once.
